scoreboard_register_file: RTL and testbench

Parametrised multi-read register file with per-register pending-write scoreboard, byte-lane writes and same-cycle write-to-read bypass. It is the next generation of the 32x32 CPU register file. The pipeline's decode stage uses it to read operands and detect RAW hazards. The write-back stage uses it to retire results and clear pending flags.

---
 rtl/scoreboard_register_file_if.sv | 32 +++
 rtl/scoreboard_register_file.sv | 86 ++++++++
 tb/tb_scoreboard_register_file.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_register_file_if.sv
// Register-file access bundle: write-back, issue and two read ports.
// Signal names follow the legacy register file so decode/write-back code ports directly.
interface scoreboard_register_file_if #(
    parameter int N     = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              WriteEn;
    logic [AW-1:0]     WriteReg;
    logic [N/8-1:0]    ByteEn;
    logic [N-1:0]      wd3;
    logic              IssueEn;
    logic [AW-1:0]     IssueReg;
    logic [AW-1:0]     ReadReg1;
    logic [AW-1:0]     ReadReg2;
    logic [N-1:0]      ReadData1;
    logic [N-1:0]      ReadData2;
    logic              ReadBusy1;
    logic              ReadBusy2;
    logic [AW:0]       BusyCount;

    modport slave (
        input  WriteEn, WriteReg, ByteEn, wd3, IssueEn, IssueReg, ReadReg1, ReadReg2,
        output ReadData1, ReadData2, ReadBusy1, ReadBusy2, BusyCount
    );

    modport master (
        output WriteEn, WriteReg, ByteEn, wd3, IssueEn, IssueReg, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, ReadBusy1, ReadBusy2, BusyCount
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// Multi-read register file with pending-write scoreboard, byte-lane writes
// and same-cycle write-to-read bypass for the decode stage's hazard checks.
module scoreboard_register_file #(
    parameter int N        = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                                 Clock,
    input  logic                                 R,
    scoreboard_register_file_if.slave            bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = N / 8;

    logic [N-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    logic             wr_ok;
    logic             iss_ok;
    logic             inc;
    logic             dec;
    logic [N-1:0]     wr_merge;

    assign wr_ok  = bus.WriteEn && !(ZERO_REG && (bus.WriteReg == '0));
    assign iss_ok = bus.IssueEn && !(ZERO_REG && (bus.IssueReg == '0));

    always_comb begin
        wr_merge = regs_q[bus.WriteReg];
        for (int unsigned k = 0; k < NB; k++) begin
            if (bus.ByteEn[k]) wr_merge[8*k +: 8] = bus.wd3[8*k +: 8];
        end
    end

    // Issue is applied after the retire so a same-register issue keeps the flag set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)  busy_d[bus.WriteReg] = 1'b0;
        if (iss_ok) busy_d[bus.IssueReg] = 1'b1;
    end

    assign inc     = iss_ok && !busy_q[bus.IssueReg];
    assign dec     = wr_ok && busy_q[bus.WriteReg] &&
                     !(iss_ok && (bus.IssueReg == bus.WriteReg));
    assign count_d = count_q + (AW+1)'(inc) - (AW+1)'(dec);

    always_ff @(posedge Clock or posedge R) begin
        if (R) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) regs_q[bus.WriteReg] <= wr_merge;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        bus.ReadData1 = regs_q[bus.ReadReg1];
        bus.ReadBusy1 = busy_q[bus.ReadReg1];
        if (ZERO_REG && (bus.ReadReg1 == '0)) begin
            bus.ReadData1 = '0;
            bus.ReadBusy1 = 1'b0;
        end else if (wr_ok && (bus.WriteReg == bus.ReadReg1)) begin
            bus.ReadData1 = wr_merge;
            bus.ReadBusy1 = iss_ok && (bus.IssueReg == bus.ReadReg1);
        end
    end

    always_comb begin
        bus.ReadData2 = regs_q[bus.ReadReg2];
        bus.ReadBusy2 = busy_q[bus.ReadReg2];
        if (ZERO_REG && (bus.ReadReg2 == '0)) begin
            bus.ReadData2 = '0;
            bus.ReadBusy2 = 1'b0;
        end else if (wr_ok && (bus.WriteReg == bus.ReadReg2)) begin
            bus.ReadData2 = wr_merge;
            bus.ReadBusy2 = iss_ok && (bus.IssueReg == bus.ReadReg2);
        end
    end

    assign bus.BusyCount = count_q;
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Drives a 32-deep ZERO_REG=1 instance and a 16-deep ZERO_REG=0 instance with
// identical directed stimulus and checks both against an array-based model.
module tb_scoreboard_register_file;
    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wreg;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ireg;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        chk_en;

    int tests;
    int fails;

    scoreboard_register_file_if #(.N(32), .DEPTH(32)) ifa ();
    scoreboard_register_file_if #(.N(32), .DEPTH(16)) ifb ();

    assign ifa.WriteEn  = we;
    assign ifa.WriteReg = wreg;
    assign ifa.ByteEn   = be;
    assign ifa.wd3      = wd;
    assign ifa.IssueEn  = ie;
    assign ifa.IssueReg = ireg;
    assign ifa.ReadReg1 = rr1;
    assign ifa.ReadReg2 = rr2;

    assign ifb.WriteEn  = we;
    assign ifb.WriteReg = wreg[3:0];
    assign ifb.ByteEn   = be;
    assign ifb.wd3      = wd;
    assign ifb.IssueEn  = ie;
    assign ifb.IssueReg = ireg[3:0];
    assign ifb.ReadReg1 = rr1[3:0];
    assign ifb.ReadReg2 = rr2[3:0];

    scoreboard_register_file #(.N(32), .DEPTH(32), .ZERO_REG(1'b1)) dut_a (
        .Clock (clk),
        .R     (rst),
        .bus   (ifa.slave)
    );

    scoreboard_register_file #(.N(32), .DEPTH(16), .ZERO_REG(1'b0)) dut_b (
        .Clock (clk),
        .R     (rst),
        .bus   (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: instance 0 = DEPTH 32 / ZERO_REG 1, instance 1 = DEPTH 16 / ZERO_REG 0.
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];
    int          dep [2] = '{32, 16};
    bit          zr  [2] = '{1'b1, 1'b0};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    function automatic bit writable(input int inst, input int a);
        return !(zr[inst] && a == 0);
    endfunction

    function automatic logic [31:0] exp_data(input int inst, input int addr);
        int a, w;
        a = addr % dep[inst];
        w = int'(wreg) % dep[inst];
        if (zr[inst] && a == 0) return 32'h0;
        if (we && w == a) return merge(m_regs[inst][a], wd, be);
        return m_regs[inst][a];
    endfunction

    function automatic logic exp_busy(input int inst, input int addr);
        int a, w, s;
        a = addr % dep[inst];
        w = int'(wreg) % dep[inst];
        s = int'(ireg) % dep[inst];
        if (zr[inst] && a == 0) return 1'b0;
        if (we && w == a) return ie && s == a;
        return m_busy[inst][a];
    endfunction

    function automatic int exp_count(input int inst);
        int c;
        c = 0;
        for (int a = 0; a < dep[inst]; a++) c += int'(m_busy[inst][a]);
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 32; a++) begin
                    m_regs[i][a] = '0;
                    m_busy[i][a] = 1'b0;
                end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int w, s;
                w = int'(wreg) % dep[i];
                s = int'(ireg) % dep[i];
                if (we && writable(i, w)) begin
                    m_regs[i][w] = merge(m_regs[i][w], wd, be);
                    m_busy[i][w] = 1'b0;
                end
                if (ie && writable(i, s)) m_busy[i][s] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("A.ReadData1", ifa.ReadData1, exp_data(0, int'(rr1)));
            chk("A.ReadData2", ifa.ReadData2, exp_data(0, int'(rr2)));
            chk("A.ReadBusy1", 32'(ifa.ReadBusy1), 32'(exp_busy(0, int'(rr1))));
            chk("A.ReadBusy2", 32'(ifa.ReadBusy2), 32'(exp_busy(0, int'(rr2))));
            chk("A.BusyCount", 32'(ifa.BusyCount), 32'(exp_count(0)));
            chk("B.ReadData1", ifb.ReadData1, exp_data(1, int'(rr1)));
            chk("B.ReadData2", ifb.ReadData2, exp_data(1, int'(rr2)));
            chk("B.ReadBusy1", 32'(ifb.ReadBusy1), 32'(exp_busy(1, int'(rr1))));
            chk("B.ReadBusy2", 32'(ifb.ReadBusy2), 32'(exp_busy(1, int'(rr2))));
            chk("B.BusyCount", 32'(ifb.BusyCount), 32'(exp_count(1)));
        end
    end

    task automatic drive(input logic w_en, input logic [4:0] w_r, input logic [3:0] b,
                         input logic [31:0] d, input logic i_en, input logic [4:0] i_r,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        we = w_en; wreg = w_r; be = b; wd = d;
        ie = i_en; ireg = i_r; rr1 = r1; rr2 = r2;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wreg = '0; be = '0; wd = '0;
        ie = 1'b0; ireg = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".A.rd1"}, ifa.ReadData1, 32'h0);
        chk({tag, ".A.rd2"}, ifa.ReadData2, 32'h0);
        chk({tag, ".A.bsy1"}, 32'(ifa.ReadBusy1), 32'h0);
        chk({tag, ".A.bsy2"}, 32'(ifa.ReadBusy2), 32'h0);
        chk({tag, ".A.cnt"}, 32'(ifa.BusyCount), 32'h0);
        chk({tag, ".B.rd1"}, ifb.ReadData1, 32'h0);
        chk({tag, ".B.bsy1"}, 32'(ifb.ReadBusy1), 32'h0);
        chk({tag, ".B.cnt"}, 32'(ifb.BusyCount), 32'h0);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_reset_outputs(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        rr1    = 5'd5;
        rr2    = 5'd0;
        idle_inputs();
        #12;
        chk_reset_outputs("por");
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Byte-lane merge on r5, with bypass visible in the write cycle.
        drive(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        drive(1'b1, 5'd5, 4'h1, 32'h000000AA, 1'b0, 5'd0, 5'd5, 5'd0);
        #2 chk("r5_bypass", ifa.ReadData1, 32'hDEADBEAA);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #2 chk("r5_stored", ifa.ReadData1, 32'hDEADBEAA);

        // r0: dropped when ZERO_REG=1, ordinary when ZERO_REG=0.
        drive(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        #2 chk("A_r0_bypass", ifa.ReadData1, 32'h0);
        chk("B_r0_bypass", ifb.ReadData1, 32'hFFFFFFFF);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #2 chk("A_r0_stored", ifa.ReadData1, 32'h0);
        chk("B_r0_stored", ifb.ReadData1, 32'hFFFFFFFF);

        // Upper-half bypass on r7.
        drive(1'b1, 5'd7, 4'hF, 32'h11111111, 1'b0, 5'd0, 5'd7, 5'd0);
        drive(1'b1, 5'd7, 4'hC, 32'h22223333, 1'b0, 5'd0, 5'd7, 5'd0);
        #2 chk("r7_bypass", ifa.ReadData1, 32'h22221111);

        // Scoreboard set/clear.
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd3);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
        #2 chk("cnt_two", 32'(ifa.BusyCount), 32'd2);
        chk("r3_busy", 32'(ifa.ReadBusy2), 32'd1);
        drive(1'b1, 5'd3, 4'hF, 32'h00000033, 1'b0, 5'd0, 5'd0, 5'd3);
        #2 chk("r3_retire_comb", 32'(ifa.ReadBusy2), 32'd0);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
        #2 chk("cnt_one", 32'(ifa.BusyCount), 32'd1);

        // Write and issue to an already-busy r4 in the same cycle.
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        drive(1'b1, 5'd4, 4'hF, 32'h44444444, 1'b1, 5'd4, 5'd4, 5'd0);
        #2 chk("r4_same_data", ifa.ReadData1, 32'h44444444);
        chk("r4_same_busy", 32'(ifa.ReadBusy1), 32'd1);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        #2 chk("r4_cnt_kept", 32'(ifa.BusyCount), 32'd2);
        chk("r4_still_busy", 32'(ifa.ReadBusy1), 32'd1);

        async_reset_pulse("rst_mid");

        // Fill the scoreboard, then reset in the middle of further issues.
        for (int i = 0; i < 32; i++)
            drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(i), 5'd1, 5'd2);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        #2 chk("A_cnt_full", 32'(ifa.BusyCount), 32'd31);
        chk("B_cnt_full", 32'(ifb.BusyCount), 32'd16);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd1, 5'd1, 5'd2);
        async_reset_pulse("rst_full");

        drive(1'b1, 5'd0, 4'hF, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #2 chk("A_r0_zero", ifa.ReadData1, 32'h0);
        chk("B_r0_data", ifb.ReadData1, 32'h12345678);

        // Mixed traffic: overlapping writes, issues and reads, checked by the model.
        for (int i = 0; i < 40; i++)
            drive(1'(i % 3 != 0), 5'((i * 3) % 32), 4'(i), 32'(i) * 32'h01010101 + 32'h00F0,
                  1'(i % 2 == 0), 5'((i * 5 + 1) % 32), 5'((i * 3) % 32), 5'((i * 5 + 1) % 32));
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
